// File: rtl/crop_stream_mc_if.sv
// AXI-Stream style beat interface used by crop_stream_mc on both sides.
// Carries TDATA/TVALID/TREADY/TLAST. TUSER (start of frame) exists only
// when CROP_SOF_RESYNC_EN is defined.
interface crop_stream_mc_if #(
  parameter int DW = 12
) ();
  logic [DW-1:0] TDATA;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
`ifdef CROP_SOF_RESYNC_EN
  logic          TUSER;

  modport master (output TDATA, TVALID, TLAST, TUSER, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, TUSER, output TREADY);
`else
  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
`endif
endinterface

// File: rtl/crop_stream_mc.sv
// crop_stream_mc: crops an OUT_ROWS x OUT_COLS window out of a raster
// IN_ROWS x IN_COLS stream and buffers the kept beats in a FWFT FIFO.
// The window corner is sampled (and clamped) on beat (0,0) of every frame.
// Optional: define CROP_SOF_RESYNC_EN to add TUSER start-of-frame resync
// and the sof_err pulse output.
module crop_stream_mc #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20,
  parameter int FIFO_DEPTH      = 16,
  localparam int DW = PIXEL_BIT_WIDTH * CHANNELS,
  localparam int RW = $clog2(IN_ROWS),
  localparam int CW = $clog2(IN_COLS),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [RW-1:0]        cfg_y1,
  input  logic [CW-1:0]        cfg_x1,
  crop_stream_mc_if.slave      pixel_in,
  crop_stream_mc_if.master     pixel_out,
  output logic                 frame_done,
`ifdef CROP_SOF_RESYNC_EN
  output logic                 sof_err,
`endif
  output logic [LW-1:0]        fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] Y1_MAX   = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] X1_MAX   = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);

  // Frame position and latched window corner
  logic [RW-1:0] row, y1_l;
  logic [CW-1:0] col, x1_l;
  logic          rdy_q;

  // FIFO storage: {last, data}
  logic [DW:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic accept, pop, push, sof, at_origin, start;
  logic [RW-1:0] cur_row, y1_c, y1_e;
  logic [CW-1:0] cur_col, x1_c, x1_e;
  logic [RW:0]   row_x, y1_x;
  logic [CW:0]   col_x, x1_x;
  logic          keep, last_w, end_row, end_col;

`ifdef CROP_SOF_RESYNC_EN
  assign sof             = pixel_in.TUSER;
  assign pixel_out.TUSER = 1'b0;
`else
  assign sof             = 1'b0;
`endif

  // Ready depends only on registered state; rdy_q holds it low during reset
  // and for the release cycle.
  assign pixel_in.TREADY  = rdy_q && (level != LW'(FIFO_DEPTH));
  assign pixel_out.TVALID = (level != '0);
  assign pixel_out.TDATA  = mem[rd_ptr][DW-1:0];
  assign pixel_out.TLAST  = pixel_out.TVALID & mem[rd_ptr][DW];
  assign fifo_level       = level;

  assign accept = pixel_in.TVALID & pixel_in.TREADY;
  assign pop    = pixel_out.TVALID & pixel_out.TREADY;

  // A TUSER beat is treated as position (0,0) regardless of the counters.
  assign at_origin = (row == '0) && (col == '0);
  assign start     = sof | at_origin;
  assign cur_row   = sof ? '0 : row;
  assign cur_col   = sof ? '0 : col;

  // Clamped window corner; on the frame's first beat it applies immediately.
  assign y1_c = (cfg_y1 > Y1_MAX) ? Y1_MAX : cfg_y1;
  assign x1_c = (cfg_x1 > X1_MAX) ? X1_MAX : cfg_x1;
  assign y1_e = start ? y1_c : y1_l;
  assign x1_e = start ? x1_c : x1_l;

  // One extra bit so corner + size cannot overflow in the upper-bound test.
  assign row_x = {1'b0, cur_row};
  assign y1_x  = {1'b0, y1_e};
  assign col_x = {1'b0, cur_col};
  assign x1_x  = {1'b0, x1_e};

  assign keep   = (row_x >= y1_x) && (row_x < y1_x + (RW+1)'(OUT_ROWS)) &&
                  (col_x >= x1_x) && (col_x < x1_x + (CW+1)'(OUT_COLS));
  assign last_w = (cur_row == y1_e + RW'(OUT_ROWS - 1)) &&
                  (cur_col == x1_e + CW'(OUT_COLS - 1));
  assign end_row = (cur_row == ROW_LAST);
  assign end_col = (cur_col == COL_LAST);
  assign push    = accept & keep;

  // Raster counters, per-frame corner latch and status pulses
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      row        <= '0;
      col        <= '0;
      y1_l       <= '0;
      x1_l       <= '0;
      rdy_q      <= 1'b0;
      frame_done <= 1'b0;
`ifdef CROP_SOF_RESYNC_EN
      sof_err    <= 1'b0;
`endif
    end else begin
      rdy_q      <= 1'b1;
      frame_done <= accept && end_row && end_col;
`ifdef CROP_SOF_RESYNC_EN
      // Error when TUSER disagrees with the counters being at the origin.
      sof_err    <= accept && (sof ^ at_origin);
`endif
      if (accept) begin
        if (start) begin
          y1_l <= y1_c;
          x1_l <= x1_c;
        end
        if (end_col) begin
          col <= '0;
          row <= end_row ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // FIFO storage write (data only, no reset needed)
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= {last_w, pixel_in.TDATA};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_crop_stream_mc.sv
// Randomized bench for crop_stream_mc. The reference model walks frame
// positions arithmetically and builds the expected output queue, per-beat
// keep flags and frame_done/sof_err expectations ahead of each run.
module tb_crop_stream_mc;
  localparam int PW = 12, CH = 1, IR = 40, IC = 40, OR = 20, OC = 20, FD = 16;
  localparam int DW = PW * CH;
  localparam int RW = $clog2(IR);
  localparam int CW = $clog2(IC);
  localparam int LW = $clog2(FD) + 1;
  localparam int FRAME = IR * IC;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [RW-1:0] cfg_y1 = '0;
  logic [CW-1:0] cfg_x1 = '0;
  logic          frame_done;
  logic [LW-1:0] fifo_level;
`ifdef CROP_SOF_RESYNC_EN
  logic          sof_err;
`endif

  crop_stream_mc_if #(.DW(DW)) pin ();
  crop_stream_mc_if #(.DW(DW)) pout ();

  crop_stream_mc #(
    .PIXEL_BIT_WIDTH(PW), .CHANNELS(CH), .IN_ROWS(IR), .IN_COLS(IC),
    .OUT_ROWS(OR), .OUT_COLS(OC), .FIFO_DEPTH(FD)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .cfg_y1     (cfg_y1),
    .cfg_x1     (cfg_x1),
    .pixel_in   (pin),
    .pixel_out  (pout),
    .frame_done (frame_done),
`ifdef CROP_SOF_RESYNC_EN
    .sof_err    (sof_err),
`endif
    .fifo_level (fifo_level)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int popped;

  // Per-beat stimulus and expectations
  logic [DW-1:0] b_data[$];
  logic [RW-1:0] b_y1[$];
  logic [CW-1:0] b_x1[$];
  bit            b_keep[$];
  bit            b_fd[$];
  bit            b_sof[$];
  bit            b_tuser[$];
  logic [DW:0]   exp_q[$];

  // Reference model: walk frame positions, latch the clamped corner at
  // position 0, record which beats land in the window and the expected output.
  task automatic build(input int nbeats, input int y1a, input int x1a,
                       input int chg_at, input int y1b, input int x1b,
                       input int sof_at, input bit rnd);
    int pos, wy, wx, ya, xa, r, c;
    bit k, se, tu;
    logic [DW-1:0] d;
    b_data.delete(); b_y1.delete(); b_x1.delete(); b_keep.delete();
    b_fd.delete(); b_sof.delete(); b_tuser.delete(); exp_q.delete();
    pos = 0; wy = 0; wx = 0;
    for (int g = 0; g < nbeats; g++) begin
      if (g == sof_at) begin
        se = (pos != 0); pos = 0; tu = 1'b1;
      end else begin
        se = 1'b0; tu = (pos == 0);
      end
      ya = (chg_at >= 0 && g >= chg_at) ? y1b : y1a;
      xa = (chg_at >= 0 && g >= chg_at) ? x1b : x1a;
      r = pos / IC;
      c = pos % IC;
      if (pos == 0) begin
        wy = (ya > IR - OR) ? IR - OR : ya;
        wx = (xa > IC - OC) ? IC - OC : xa;
      end
      d = rnd ? DW'($urandom) : DW'(r * IC + c);
      k = (r >= wy) && (r < wy + OR) && (c >= wx) && (c < wx + OC);
      if (k) exp_q.push_back({((r == wy + OR - 1) && (c == wx + OC - 1)), d});
      b_data.push_back(d);
      b_y1.push_back(RW'(ya));
      b_x1.push_back(CW'(xa));
      b_keep.push_back(k);
      b_fd.push_back(pos == FRAME - 1);
      b_sof.push_back(se);
      b_tuser.push_back(tu);
      pos = (pos + 1) % FRAME;
    end
  endtask

  // Drives the built beats with random gaps/backpressure and checks every
  // output handshake, the level, ready/valid and the status pulses per cycle.
  // abort_at >= 0 stops after that many accepted beats without draining.
  task automatic run(input int vprob, input int rprob, input int abort_at,
                     input bit bp_mode);
    int g, cyc, lvl, limit, nb;
    bit have, fd_exp, se_exp, released;
    g = 0; cyc = 0; lvl = 0; have = 0; fd_exp = 0; se_exp = 0; released = 0;
    popped = 0;
    nb = b_data.size();
    limit = (abort_at >= 0) ? abort_at : nb;
    while (!(g >= limit && (abort_at >= 0 || exp_q.size() == 0))) begin
      if (cyc++ > 30000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout accepted=%0d of %0d left=%0d", g, limit, exp_q.size());
        break;
      end
      @(negedge ap_clk);
      if (!have && g < limit && $urandom_range(99) < vprob) begin
        have = 1'b1;
        pin.TDATA = b_data[g];
        cfg_y1 = b_y1[g];
        cfg_x1 = b_x1[g];
`ifdef CROP_SOF_RESYNC_EN
        pin.TUSER = b_tuser[g];
`endif
      end
      pin.TVALID = have;
      if (bp_mode && !released) pout.TREADY = 1'b0;
      else pout.TREADY = ($urandom_range(99) < rprob);
      #1;
      n_cmp++;
      if (fifo_level !== LW'(lvl)) begin
        n_bad++; $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, lvl);
      end
      n_cmp++;
      if (pout.TVALID !== (lvl != 0)) begin
        n_bad++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, pout.TVALID, lvl != 0);
      end
      n_cmp++;
      if (pin.TREADY !== (lvl != FD)) begin
        n_bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, pin.TREADY, lvl != FD);
      end
      n_cmp++;
      if (frame_done !== fd_exp) begin
        n_bad++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, fd_exp);
      end
`ifdef CROP_SOF_RESYNC_EN
      n_cmp++;
      if (sof_err !== se_exp) begin
        n_bad++; $display("FAIL sof_err cyc=%0d got=%b exp=%b", cyc, sof_err, se_exp);
      end
`endif
      fd_exp = 1'b0;
      se_exp = 1'b0;
      if (bp_mode && !released && pin.TREADY === 1'b0) begin
        // Full after the 16th kept beat, input (10,25) -> 426 beats accepted
        n_cmp++;
        if (g != 10 * IC + 25 + 1) begin
          n_bad++; $display("FAIL bp_stall_point got=%0d exp=%0d", g, 10 * IC + 26);
        end
        released = 1'b1;
      end
      if (pout.TVALID === 1'b1 && pout.TREADY) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL extra_beat data=%0d last=%b", pout.TDATA, pout.TLAST);
        end else begin
          if ({pout.TLAST, pout.TDATA} !== exp_q[0]) begin
            n_bad++;
            $display("FAIL out_beat idx=%0d got=%b/%0d exp=%b/%0d", popped,
                     pout.TLAST, pout.TDATA, exp_q[0][DW], exp_q[0][DW-1:0]);
          end
          void'(exp_q.pop_front());
        end
        popped++;
        lvl--;
      end
      if (have && pin.TREADY === 1'b1) begin
        lvl += int'(b_keep[g]);
        fd_exp = b_fd[g];
        se_exp = b_sof[g];
        g++;
        have = 1'b0;
      end
    end
    @(negedge ap_clk);
    pin.TVALID = 1'b0;
`ifdef CROP_SOF_RESYNC_EN
    pin.TUSER = 1'b0;
`endif
    pout.TREADY = 1'b0;
  endtask

  task automatic check_idle(input string name, input int exp_pop, input int got_pop);
    @(negedge ap_clk); #1;
    n_cmp++;
    if (got_pop != exp_pop) begin
      n_bad++; $display("FAIL %s_count got=%0d exp=%0d", name, got_pop, exp_pop);
    end
    n_cmp++;
    if (fifo_level !== '0 || pout.TVALID !== 1'b0) begin
      n_bad++; $display("FAIL %s_drain level=%0d valid=%b exp=0/0", name, fifo_level, pout.TVALID);
    end
  endtask

  task automatic test_reset();
    pin.TVALID = 1'b0; pin.TDATA = '0; pin.TLAST = 1'b0; pout.TREADY = 1'b0;
`ifdef CROP_SOF_RESYNC_EN
    pin.TUSER = 1'b0;
`endif
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    n_cmp++;
    if ({pout.TVALID, pout.TLAST, frame_done, pin.TREADY} !== 4'b0 || fifo_level !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b l=%b fd=%b rdy=%b lvl=%0d exp all 0",
               pout.TVALID, pout.TLAST, frame_done, pin.TREADY, fifo_level);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    n_cmp++;
    if (pin.TREADY !== 1'b0) begin
      n_bad++; $display("FAIL ready_before_clock got=%b exp=0", pin.TREADY);
    end
    @(posedge ap_clk); #1;
    n_cmp++;
    if (pin.TREADY !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_release got=%b exp=1", pin.TREADY);
    end
  endtask

  task automatic test_basic_crop();
    build(FRAME, 10, 10, -1, 0, 0, -1, 1'b0);
    n_cmp++;
    if (exp_q[0][DW-1:0] != DW'(410) || exp_q[exp_q.size()-1] != {1'b1, DW'(1189)}) begin
      n_bad++; $display("FAIL model_basic first=%0d last=%0d exp 410/1189", exp_q[0][DW-1:0], exp_q[exp_q.size()-1][DW-1:0]);
    end
    run(100, 100, -1, 1'b0);
    check_idle("basic", 400, popped);
  endtask

  task automatic test_backpressure();
    build(FRAME, 10, 10, -1, 0, 0, -1, 1'b0);
    run(100, 100, -1, 1'b1);
    check_idle("backpressure", 400, popped);
  endtask

  task automatic test_clamp();
    build(FRAME, 35, 39, -1, 0, 0, -1, 1'b0);
    run(70, 60, -1, 1'b0);
    check_idle("clamp", 400, popped);
  endtask

  task automatic test_cfg_midframe();
    build(2 * FRAME, 10, 10, 500, 0, 0, -1, 1'b0);
    run(80, 70, -1, 1'b0);
    check_idle("cfg_midframe", 800, popped);
  endtask

  task automatic test_reset_midframe();
    build(FRAME, 10, 10, -1, 0, 0, -1, 1'b0);
    run(100, 20, 460, 1'b0);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pout.TVALID !== 1'b0 || fifo_level !== '0 || pin.TREADY !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got v=%b lvl=%0d rdy=%b exp 0/0/0", pout.TVALID, fifo_level, pin.TREADY);
    end
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    build(FRAME, 10, 10, -1, 0, 0, -1, 1'b0);
    run(75, 75, -1, 1'b0);
    check_idle("reset_midframe", 400, popped);
  endtask

  task automatic test_random_data();
    int ya, xa;
    ya = $urandom_range(IR - 1);
    xa = $urandom_range(IC - 1);
    build(FRAME, ya, xa, -1, 0, 0, -1, 1'b1);
    run(60, 50, -1, 1'b0);
    check_idle("random_data", OR * OC, popped);
  endtask

  task automatic test_back_to_back();
    int ya, xa, yb, xb;
    ya = $urandom_range(IR - 1); xa = $urandom_range(IC - 1);
    yb = $urandom_range(IR - 1); xb = $urandom_range(IC - 1);
    build(2 * FRAME, ya, xa, FRAME, yb, xb, -1, 1'b1);
    run(100, 100, -1, 1'b0);
    check_idle("back_to_back", 2 * OR * OC, popped);
  endtask

`ifdef CROP_SOF_RESYNC_EN
  task automatic test_sof_resync();
    build(700 + FRAME, 10, 10, -1, 0, 0, 700, 1'b0);
    run(85, 80, -1, 1'b0);
    check_idle("sof_resync", 7 * OC + 10 + 400, popped);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_crop();
    test_backpressure();
    test_clamp();
    test_cfg_midframe();
    test_reset_midframe();
    test_random_data();
    test_back_to_back();
`ifdef CROP_SOF_RESYNC_EN
    test_sof_resync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
